// File: rtl/load_align_seq_unit.sv
// rtl/load_align_seq_unit.sv - sequential load unit: aligned bus beats, byte merge, sign/zero extend
//
// Purpose
//   Takes one load at a time from the MEM stage, issues one aligned read beat
//   (two if the access crosses a beat boundary and MISALIGN_SPLIT=1), then
//   extracts the addressed bytes and sign/zero-extends them. Misaligned
//   crossing loads trap when splitting is disabled; bus errors trap as load
//   access faults. Illegal load types complete with zero data and no trap.
//
// Parameters
//   XLEN            32 or 64; NB = XLEN/8 bytes per beat
//   MISALIGN_SPLIT  1: split boundary-crossing loads, 0: trap them
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid_i / req_ready_o    load request handshake (ready only in IDLE)
//   req_type_i [2:0]             funct3 load type
//   req_addr_i [XLEN-1:0]        byte address
//   mem_valid_o / mem_ready_i    bus read request handshake
//   mem_addr_o [XLEN-1:0]        aligned beat address
//   mem_rvalid_i, mem_rdata_i, mem_err_i   bus read return (err qualified by rvalid)
//   resp_valid_o / resp_ready_i  result handshake
//   resp_data_o [XLEN-1:0]       formatted load data
//   resp_rmask_o [2*NB-1:0]      byte mask relative to the first beat address
//   resp_trap_o, resp_trap_code_o [30:0]   trap flag and cause

module load_align_seq_unit #(
  parameter int XLEN           = 32,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0]            req_type_i,
  input  logic [XLEN-1:0]       req_addr_i,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic [XLEN-1:0]       mem_addr_o,
  input  logic                  mem_rvalid_i,
  input  logic [XLEN-1:0]       mem_rdata_i,
  input  logic                  mem_err_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [XLEN-1:0]       resp_data_o,
  output logic [2*(XLEN/8)-1:0] resp_rmask_o,
  output logic                  resp_trap_o,
  output logic [30:0]           resp_trap_code_o
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  localparam logic [30:0] TRAP_CODE_LOAD_ADDR_MISALIGNED = 31'd4;
  localparam logic [30:0] TRAP_CODE_LOAD_ACCESS_FAULT    = 31'd5;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ0  = 3'd1;
  localparam logic [2:0] S_WAIT0 = 3'd2;
  localparam logic [2:0] S_REQ1  = 3'd3;
  localparam logic [2:0] S_WAIT1 = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  logic [2:0]        state_q;
  logic [2:0]        type_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   beat0_q;
  logic              cross_q;
  logic [XLEN-1:0]   resp_data_q;
  logic [2*NB-1:0]   resp_rmask_q;
  logic              resp_trap_q;
  logic [30:0]       resp_code_q;

  // Request decode, evaluated on the incoming request in IDLE.
  logic [OFFW-1:0]   req_off;
  logic [3:0]        req_size;
  logic [4:0]        req_end;
  logic              req_cross;
  logic              req_illegal;

  assign req_off   = req_addr_i[OFFW-1:0];
  assign req_size  = 4'd1 << req_type_i[1:0];
  assign req_end   = 5'(req_off) + 5'(req_size);
  assign req_cross = (req_end > 5'(NB));

  // LD and LWU only exist on RV64; funct3 111 is never a load.
  always_comb begin
    req_illegal = (req_type_i == 3'b111);
    if ((XLEN == 32) && ((req_type_i == 3'b011) || (req_type_i == 3'b110))) begin
      req_illegal = 1'b1;
    end
  end

  // Latched request view used by the bus and merge logic.
  logic [OFFW-1:0]   off_q;
  logic [3:0]        size_q;
  logic [XLEN-1:0]   beat0_addr;
  logic [XLEN-1:0]   beat1_addr;

  assign off_q      = addr_q[OFFW-1:0];
  assign size_q     = 4'd1 << type_q[1:0];
  assign beat0_addr = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
  // Natural modulo-2^XLEN wrap for a crossing access at the top of memory.
  assign beat1_addr = beat0_addr + XLEN'(NB);

  // Merge: in WAIT1 the pair is {new beat, stored beat0}; for a single beat
  // the upper half is zero and never selected because off+S <= NB.
  logic [XLEN-1:0]   merge_hi;
  logic [XLEN-1:0]   merge_lo;
  logic [XLEN-1:0]   shifted;
  logic              sign_bit;
  logic [XLEN-1:0]   fmt_data;

  assign merge_hi = (state_q == S_WAIT1) ? mem_rdata_i : '0;
  assign merge_lo = (state_q == S_WAIT1) ? beat0_q     : mem_rdata_i;
  assign shifted  = XLEN'({merge_hi, merge_lo} >> {off_q, 3'b000});

  always_comb begin
    case (size_q)
      4'd1:    sign_bit = shifted[7];
      4'd2:    sign_bit = shifted[15];
      4'd4:    sign_bit = shifted[31];
      default: sign_bit = shifted[XLEN-1];
    endcase
    // funct3[2] selects the unsigned variants.
    if (type_q[2]) begin
      sign_bit = 1'b0;
    end
    fmt_data = '0;
    for (int b = 0; b < NB; b++) begin
      fmt_data[8*b +: 8] = (b < int'(size_q)) ? shifted[8*b +: 8] : {8{sign_bit}};
    end
  end

  // Byte mask: S ones shifted up by the offset inside the first beat.
  logic [2*NB-1:0]   size_mask;
  logic [2*NB-1:0]   rmask_calc;

  always_comb begin
    size_mask = '0;
    for (int i = 0; i < 2*NB; i++) begin
      size_mask[i] = (i < int'(size_q));
    end
  end

  assign rmask_calc = size_mask << off_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      type_q       <= '0;
      addr_q       <= '0;
      beat0_q      <= '0;
      cross_q      <= 1'b0;
      resp_data_q  <= '0;
      resp_rmask_q <= '0;
      resp_trap_q  <= 1'b0;
      resp_code_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            type_q  <= req_type_i;
            addr_q  <= req_addr_i;
            cross_q <= req_cross;
            if (req_illegal) begin
              resp_data_q  <= '0;
              resp_rmask_q <= '0;
              resp_trap_q  <= 1'b0;
              resp_code_q  <= '0;
              state_q      <= S_RESP;
            end else if (req_cross && (MISALIGN_SPLIT == 1'b0)) begin
              resp_data_q  <= '0;
              resp_rmask_q <= '0;
              resp_trap_q  <= 1'b1;
              resp_code_q  <= TRAP_CODE_LOAD_ADDR_MISALIGNED;
              state_q      <= S_RESP;
            end else begin
              state_q <= S_REQ0;
            end
          end
        end

        S_REQ0: begin
          if (mem_ready_i) begin
            state_q <= S_WAIT0;
          end
        end

        S_WAIT0: begin
          if (mem_rvalid_i) begin
            beat0_q <= mem_rdata_i;
            if (mem_err_i) begin
              resp_data_q  <= '0;
              resp_rmask_q <= '0;
              resp_trap_q  <= 1'b1;
              resp_code_q  <= TRAP_CODE_LOAD_ACCESS_FAULT;
              state_q      <= S_RESP;
            end else if (cross_q) begin
              state_q <= S_REQ1;
            end else begin
              resp_data_q  <= fmt_data;
              resp_rmask_q <= rmask_calc;
              resp_trap_q  <= 1'b0;
              resp_code_q  <= '0;
              state_q      <= S_RESP;
            end
          end
        end

        S_REQ1: begin
          if (mem_ready_i) begin
            state_q <= S_WAIT1;
          end
        end

        S_WAIT1: begin
          if (mem_rvalid_i) begin
            // An error on the second beat discards the stored first beat.
            if (mem_err_i) begin
              resp_data_q  <= '0;
              resp_rmask_q <= '0;
              resp_trap_q  <= 1'b1;
              resp_code_q  <= TRAP_CODE_LOAD_ACCESS_FAULT;
            end else begin
              resp_data_q  <= fmt_data;
              resp_rmask_q <= rmask_calc;
              resp_trap_q  <= 1'b0;
              resp_code_q  <= '0;
            end
            state_q <= S_RESP;
          end
        end

        S_RESP: begin
          if (resp_ready_i) begin
            resp_data_q  <= '0;
            resp_rmask_q <= '0;
            resp_trap_q  <= 1'b0;
            resp_code_q  <= '0;
            state_q      <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o      = (state_q == S_IDLE);
  assign mem_valid_o      = (state_q == S_REQ0) || (state_q == S_REQ1);
  assign mem_addr_o       = (state_q == S_REQ1) ? beat1_addr : beat0_addr;
  assign resp_valid_o     = (state_q == S_RESP);
  assign resp_data_o      = resp_data_q;
  assign resp_rmask_o     = resp_rmask_q;
  assign resp_trap_o      = resp_trap_q;
  assign resp_trap_code_o = resp_code_q;

endmodule

// File: tb/tb_load_align_seq_unit.sv
// tb/tb_load_align_seq_unit.sv - scoreboard bench for load_align_seq_unit (XLEN=32 split, XLEN=64 trap)

module tb_load_align_seq_unit;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] rdata;
    logic        err;
    int          stall;
    int          rv_delay;
  } beat_t;

  typedef struct {
    string       name;
    logic [63:0] data;
    logic [15:0] rmask;
    logic        trap;
    logic [30:0] code;
    int          stall;
    int          lat;
    int          t_acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [2:0]  req_type   [2];
  logic [63:0] req_addr   [2];
  logic        mem_valid  [2];
  logic        mem_ready  [2];
  logic [63:0] mem_addr   [2];
  logic        mem_rvalid [2];
  logic [63:0] mem_rdata  [2];
  logic        mem_err    [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [63:0] resp_data  [2];
  logic [15:0] resp_rmask [2];
  logic        resp_trap  [2];
  logic [30:0] resp_code  [2];

  logic        a_req_ready, a_mem_valid, a_resp_valid, a_resp_trap;
  logic [31:0] a_mem_addr, a_resp_data;
  logic [7:0]  a_resp_rmask;
  logic [30:0] a_resp_code;
  logic        b_req_ready, b_mem_valid, b_resp_valid, b_resp_trap;
  logic [63:0] b_mem_addr, b_resp_data;
  logic [15:0] b_resp_rmask;
  logic [30:0] b_resp_code;

  beat_t beat_q [2][$];
  exp_t  exp_q  [2][$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    hs_cnt  [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  load_align_seq_unit #(.XLEN(32), .MISALIGN_SPLIT(1'b1)) u_dut_a (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[0]), .req_ready_o(a_req_ready),
    .req_type_i(req_type[0]), .req_addr_i(req_addr[0][31:0]),
    .mem_valid_o(a_mem_valid), .mem_ready_i(mem_ready[0]), .mem_addr_o(a_mem_addr),
    .mem_rvalid_i(mem_rvalid[0]), .mem_rdata_i(mem_rdata[0][31:0]), .mem_err_i(mem_err[0]),
    .resp_valid_o(a_resp_valid), .resp_ready_i(resp_ready[0]),
    .resp_data_o(a_resp_data), .resp_rmask_o(a_resp_rmask),
    .resp_trap_o(a_resp_trap), .resp_trap_code_o(a_resp_code)
  );

  load_align_seq_unit #(.XLEN(64), .MISALIGN_SPLIT(1'b0)) u_dut_b (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[1]), .req_ready_o(b_req_ready),
    .req_type_i(req_type[1]), .req_addr_i(req_addr[1]),
    .mem_valid_o(b_mem_valid), .mem_ready_i(mem_ready[1]), .mem_addr_o(b_mem_addr),
    .mem_rvalid_i(mem_rvalid[1]), .mem_rdata_i(mem_rdata[1]), .mem_err_i(mem_err[1]),
    .resp_valid_o(b_resp_valid), .resp_ready_i(resp_ready[1]),
    .resp_data_o(b_resp_data), .resp_rmask_o(b_resp_rmask),
    .resp_trap_o(b_resp_trap), .resp_trap_code_o(b_resp_code)
  );

  assign req_ready[0]  = a_req_ready;
  assign mem_valid[0]  = a_mem_valid;
  assign mem_addr[0]   = {32'h0, a_mem_addr};
  assign resp_valid[0] = a_resp_valid;
  assign resp_data[0]  = {32'h0, a_resp_data};
  assign resp_rmask[0] = {8'h0, a_resp_rmask};
  assign resp_trap[0]  = a_resp_trap;
  assign resp_code[0]  = a_resp_code;
  assign req_ready[1]  = b_req_ready;
  assign mem_valid[1]  = b_mem_valid;
  assign mem_addr[1]   = b_mem_addr;
  assign resp_valid[1] = b_resp_valid;
  assign resp_data[1]  = b_resp_data;
  assign resp_rmask[1] = b_resp_rmask;
  assign resp_trap[1]  = b_resp_trap;
  assign resp_code[1]  = b_resp_code;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Bus model: pops one scripted beat per request, checks its address every
  // cycle it is presented, stalls ready, then returns rvalid after rv_delay.
  task automatic responder(input int g);
    beat_t       b;
    bit          active = 1'b0;
    bit          pend = 1'b0;
    int          stall_left = 0;
    int          cnt = 0;
    logic [63:0] pd = '0;
    logic        pe = 1'b0;
    forever begin
      @(negedge clk);
      mem_rvalid[g] = 1'b0;
      mem_err[g]    = 1'b0;
      mem_rdata[g]  = '0;
      mem_ready[g]  = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          mem_rvalid[g] = 1'b1;
          mem_rdata[g]  = pd;
          mem_err[g]    = pe;
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (mem_valid[g]) begin
        if (!active) begin
          if (beat_q[g].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL bus%0d unexpected request: got addr %h, expected no request", g, mem_addr[g]);
            continue;
          end
          b = beat_q[g].pop_front();
          active = 1'b1;
          stall_left = b.stall;
        end
        check($sformatf("bus%0d addr", g), mem_addr[g], b.addr);
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          mem_ready[g] = 1'b1;
          hs_cnt[g]++;
          active = 1'b0;
          pend = 1'b1;
          cnt = b.rv_delay;
          pd = b.rdata;
          pe = b.err;
        end
      end
    end
  endtask

  // Monitor: compares each presented response with the scoreboard head,
  // holding resp_ready low for the scripted stall while checking stability.
  task automatic monitor(input int g);
    exp_t        e;
    bit          seen = 1'b0;
    int          stall_left = 0;
    logic [63:0] sd = '0;
    logic [15:0] sm = '0;
    logic        st = 1'b0;
    logic [30:0] sc = '0;
    forever begin
      @(negedge clk);
      resp_ready[g] = 1'b1;
      if (rst) begin
        seen = 1'b0;
        continue;
      end
      if (!resp_valid[g]) continue;
      if (!seen) begin
        if (exp_q[g].size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL resp%0d unexpected: got data %h, expected no response", g, resp_data[g]);
          continue;
        end
        e = exp_q[g][0];
        seen = 1'b1;
        stall_left = e.stall;
        sd = resp_data[g];
        sm = resp_rmask[g];
        st = resp_trap[g];
        sc = resp_code[g];
        if (e.lat >= 0) check({e.name, " latency"}, 64'(cyc - e.t_acc), 64'(e.lat));
      end else begin
        check({e.name, " stable data"}, resp_data[g], sd);
        check({e.name, " stable rmask"}, 64'(resp_rmask[g]), 64'(sm));
        check({e.name, " stable trap"}, 64'({resp_trap[g], resp_code[g]}), 64'({st, sc}));
      end
      if (stall_left > 0) begin
        resp_ready[g] = 1'b0;
        stall_left--;
      end else begin
        check({e.name, " data"}, resp_data[g], e.data);
        check({e.name, " rmask"}, 64'(resp_rmask[g]), 64'(e.rmask));
        check({e.name, " trap"}, 64'(resp_trap[g]), 64'(e.trap));
        check({e.name, " code"}, 64'(resp_code[g]), 64'(e.code));
        void'(exp_q[g].pop_front());
        seen = 1'b0;
      end
    end
  endtask

  task automatic wait_idle(input int g);
    int n = 0;
    @(negedge clk);
    while (!req_ready[g] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[g]) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle%0d timeout: got req_ready 0, expected 1", g);
    end
  endtask

  task automatic push_beat(input int g, input logic [63:0] addr, input logic [63:0] rdata,
                           input logic err, input int stall, input int rv_delay);
    beat_t b;
    b.addr = addr; b.rdata = rdata; b.err = err; b.stall = stall; b.rv_delay = rv_delay;
    beat_q[g].push_back(b);
  endtask

  task automatic issue(input int g, input string nm, input logic [2:0] typ, input logic [63:0] addr,
                       input logic [63:0] data, input logic [15:0] rmask, input logic trap,
                       input logic [30:0] code, input int lat, input int stall, input int nbeats);
    exp_t e;
    int   h0;
    wait_idle(g);
    h0 = hs_cnt[g];
    e.name = nm; e.data = data; e.rmask = rmask; e.trap = trap; e.code = code;
    e.stall = stall; e.lat = lat; e.t_acc = cyc;
    exp_q[g].push_back(e);
    req_valid[g] = 1'b1;
    req_type[g]  = typ;
    req_addr[g]  = addr;
    @(negedge clk);
    req_valid[g] = 1'b0;
    wait_idle(g);
    check({nm, " bus beats"}, 64'(hs_cnt[g] - h0), 64'(nbeats));
  endtask

  initial responder(0);
  initial responder(1);
  initial monitor(0);
  initial monitor(1);

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got no completion within 20000 cycles, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      req_valid[g] = 1'b0; req_type[g] = '0; req_addr[g] = '0; hs_cnt[g] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("reset%0d req_ready", g), 64'(req_ready[g]), 64'd1);
      check($sformatf("reset%0d mem_valid", g), 64'(mem_valid[g]), 64'd0);
      check($sformatf("reset%0d resp_valid", g), 64'(resp_valid[g]), 64'd0);
      check($sformatf("reset%0d data", g), resp_data[g], 64'd0);
      check($sformatf("reset%0d rmask/trap/code", g),
            64'({resp_rmask[g], resp_trap[g], resp_code[g]}), 64'd0);
    end

    // XLEN=32, split enabled
    push_beat(0, 64'h1000, 64'h80FF_1234, 1'b0, 0, 0);
    issue(0, "a_lb", 3'b000, 64'h1003, 64'hFFFF_FF80, 16'h08, 1'b0, 31'd0, 3, 0, 1);
    push_beat(0, 64'h2000, 64'hBEEF_0000, 1'b0, 0, 0);
    issue(0, "a_lhu", 3'b101, 64'h2002, 64'h0000_BEEF, 16'h0C, 1'b0, 31'd0, 3, 0, 1);
    push_beat(0, 64'h3000, 64'hAABB_CCDD, 1'b0, 0, 0);
    push_beat(0, 64'h3004, 64'h1122_3344, 1'b0, 0, 0);
    issue(0, "a_lw_split", 3'b010, 64'h3003, 64'h2233_44AA, 16'h78, 1'b0, 31'd0, 5, 0, 2);
    issue(0, "a_ld_illegal", 3'b011, 64'h10, 64'h0, 16'h0, 1'b0, 31'd0, 1, 0, 0);
    issue(0, "a_lwu_illegal", 3'b110, 64'h20, 64'h0, 16'h0, 1'b0, 31'd0, 1, 0, 0);
    push_beat(0, 64'h4000, 64'h8001_5678, 1'b0, 5, 0);
    issue(0, "a_lh_backpressure", 3'b001, 64'h4002, 64'hFFFF_8001, 16'h0C, 1'b0, 31'd0, -1, 3, 1);
    push_beat(0, 64'hFFFF_FFFC, 64'h7F00_0000, 1'b0, 0, 0);
    push_beat(0, 64'h0000_0000, 64'h0000_00FF, 1'b0, 0, 0);
    issue(0, "a_lh_wrap", 3'b001, 64'hFFFF_FFFF, 64'hFFFF_FF7F, 16'h18, 1'b0, 31'd0, 5, 0, 2);
    push_beat(0, 64'h5000, 64'h1111_1111, 1'b0, 0, 0);
    push_beat(0, 64'h5004, 64'h2222_2222, 1'b1, 0, 0);
    issue(0, "a_lw_fault_beat1", 3'b010, 64'h5002, 64'h0, 16'h0, 1'b1, 31'd5, 5, 0, 2);

    // Reset while in WAIT0; the late read return must be ignored.
    wait_idle(0);
    push_beat(0, 64'h6000, 64'hDEAD_BEEF, 1'b0, 0, 2);
    req_valid[0] = 1'b1; req_type[0] = 3'b010; req_addr[0] = 64'h6000;
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("rst_mid mem_valid in wait", 64'(mem_valid[0]), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid req_ready", 64'(req_ready[0]), 64'd1);
    @(negedge clk);
    check("rst_mid late rvalid present", 64'(mem_rvalid[0]), 64'd1);
    @(negedge clk);
    check("rst_mid resp_valid after late rvalid", 64'(resp_valid[0]), 64'd0);
    check("rst_mid req_ready after late rvalid", 64'(req_ready[0]), 64'd1);
    check("rst_mid mem_valid after late rvalid", 64'(mem_valid[0]), 64'd0);
    push_beat(0, 64'h7000, 64'h0000_9900, 1'b0, 0, 0);
    issue(0, "a_lbu_after_rst", 3'b100, 64'h7001, 64'h99, 16'h02, 1'b0, 31'd0, 3, 0, 1);

    // XLEN=64, misaligned loads trap
    push_beat(1, 64'h8, 64'h1234, 1'b1, 0, 0);
    issue(1, "b_ld_fault", 3'b011, 64'h8, 64'h0, 16'h0, 1'b1, 31'd5, 3, 0, 1);
    push_beat(1, 64'h8, 64'h8000_0001_DEAD_BEEF, 1'b0, 0, 0);
    issue(1, "b_lwu", 3'b110, 64'hC, 64'h0000_0000_8000_0001, 16'h00F0, 1'b0, 31'd0, 3, 0, 1);
    issue(1, "b_lh_misaligned", 3'b001, 64'h0FFF, 64'h0, 16'h0, 1'b1, 31'd4, 1, 0, 0);
    push_beat(1, 64'h10, 64'h89AB_CDEF_0000_0000, 1'b0, 0, 0);
    issue(1, "b_lw", 3'b010, 64'h14, 64'hFFFF_FFFF_89AB_CDEF, 16'h00F0, 1'b0, 31'd0, 3, 0, 1);
    push_beat(1, 64'h20, 64'h0123_4567_89AB_CDEF, 1'b0, 0, 0);
    issue(1, "b_ld", 3'b011, 64'h20, 64'h0123_4567_89AB_CDEF, 16'h00FF, 1'b0, 31'd0, 3, 0, 1);
    issue(1, "b_f3_111", 3'b111, 64'h40, 64'h0, 16'h0, 1'b0, 31'd0, 1, 0, 0);
    push_beat(1, 64'h0, 64'h8000_0000_0000_0000, 1'b0, 0, 0);
    issue(1, "b_lb_top", 3'b000, 64'h7, 64'hFFFF_FFFF_FFFF_FF80, 16'h0080, 1'b0, 31'd0, 3, 0, 1);
    push_beat(1, 64'h8, 64'h7FFE_0000_0000_0000, 1'b0, 0, 0);
    issue(1, "b_lh_fits", 3'b001, 64'hE, 64'h7FFE, 16'h00C0, 1'b0, 31'd0, 3, 0, 1);

    repeat (5) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("end%0d pending responses", g), 64'(exp_q[g].size()), 64'd0);
      check($sformatf("end%0d unused beats", g), 64'(beat_q[g].size()), 64'd0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
